// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and helpers.
// Holds the transmit FSM state enum, the parity helper and the baud divisor function.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int MAX_DATA_BITS = 8;

    // Even parity over a zero-extended word; the receiver and
    // loopback checker use the same function so all ends agree.
    function automatic logic calc_parity(
        input logic [MAX_DATA_BITS-1:0] data
    );
        return ^data;
    endfunction

    function automatic int baud_divisor(
        input int sysclk,
        input int baud
    );
        return sysclk / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer, counts DIVISOR-1 down to 0.
// Ports: clk, rst (sync, active-high), restart (reload), tick (period end).
module uart_baud_gen #(
    parameter int DIVISOR = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(DIVISOR + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    // Suppressed while held in restart so an idle owner never
    // sees a spurious period end.
    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + data MSB first + opt. even parity + stops.
// Ports: SysClk, Rst, Tx_Data, Transmit_Start, CTS in; Tx, Tx_Busy, Tx_Done out.
module uart_tx
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Transmit_Start,
    input  logic                 CTS,
    output logic                 Tx,
    output logic                 Tx_Busy,
    output logic                 Tx_Done
);

    localparam int DIVISOR = baud_divisor(SYSCLK_RATE, BAUD_RATE);
    localparam int TX_BITS = 1 + DATA_BITS + PARITY_BIT + STOP_BITS;
    localparam int BW      = $clog2(TX_BITS + 1);

    // Bit indices: 0 start, 1..DATA_BITS data, then parity, then stops.
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(TX_BITS - 1);

    if (DIVISOR < 1) begin : g_div_chk
        $error("uart_tx: SYSCLK_RATE/BAUD_RATE must be >= 1");
    end
    if (DATA_BITS < 1 || DATA_BITS > MAX_DATA_BITS) begin : g_data_chk
        $error("uart_tx: DATA_BITS must be 1..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
        $error("uart_tx: STOP_BITS must be 1..2");
    end

    tx_state_e state;
    tx_state_e state_next;

    logic [DATA_BITS-1:0]     shreg;
    logic                     parity;
    logic [BW-1:0]            bit_cnt;
    logic [MAX_DATA_BITS-1:0] data_ext;
    logic                     tick;
    logic                     restart;
    logic                     accept;
    logic                     tx_bit;

    uart_baud_gen #(
        .DIVISOR(DIVISOR)
    ) u_baud (
        .clk    (SysClk),
        .rst    (Rst),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        data_ext = '0;
        data_ext[DATA_BITS-1:0] = Tx_Data;
    end

    assign accept = (state == IDLE) && Transmit_Start && CTS;

    always_ff @(posedge SysClk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Timer is held loaded while idle, so the first period of the
    // start bit is a full DIVISOR cycles from acceptance.
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        unique case (state)
            IDLE: begin
                restart = 1'b1;
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick && bit_cnt == LAST_DATA) begin
                    state_next = (PARITY_BIT == 1) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick && bit_cnt == LAST_BIT) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_bit = 1'b1;
        unique case (state)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = shreg[DATA_BITS-1];
            PARITY:  tx_bit = parity;
            default: tx_bit = 1'b1;
        endcase
    end

    always_ff @(posedge SysClk) begin
        if (Rst) begin
            shreg   <= '0;
            parity  <= 1'b0;
            bit_cnt <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
            if (accept) begin
                shreg  <= Tx_Data;
                parity <= calc_parity(data_ext);
            end
        end else if (tick) begin
            bit_cnt <= bit_cnt + BW'(1);
            if (state == DATA) begin
                shreg <= shreg << 1;
            end
        end
    end

    // Outputs trail the state by one register stage; Tx_Done fires
    // on the first cycle Tx_Busy falls after a frame.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            Tx      <= 1'b1;
            Tx_Busy <= 1'b0;
            Tx_Done <= 1'b0;
        end else begin
            Tx      <= tx_bit;
            Tx_Busy <= (state != IDLE);
            Tx_Done <= (state == IDLE) && Tx_Busy;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a frame scoreboard.
// DIVISOR=16; second instance runs without parity and with one stop bit.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       np_start = 1'b0;
    logic       cts = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx, busy, done;
    logic       np_tx, np_busy, np_done;

    int n_assert = 0;
    int n_fail = 0;

    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_tx #(
        .SYSCLK_RATE(160),
        .BAUD_RATE  (10),
        .DATA_BITS  (8),
        .PARITY_BIT (1),
        .STOP_BITS  (2)
    ) u_dut (
        .SysClk        (clk),
        .Rst           (rst),
        .Tx_Data       (data),
        .Transmit_Start(start),
        .CTS           (cts),
        .Tx            (tx),
        .Tx_Busy       (busy),
        .Tx_Done       (done)
    );

    uart_tx #(
        .SYSCLK_RATE(160),
        .BAUD_RATE  (10),
        .DATA_BITS  (8),
        .PARITY_BIT (0),
        .STOP_BITS  (1)
    ) u_np (
        .SysClk        (clk),
        .Rst           (rst),
        .Tx_Data       (data),
        .Transmit_Start(np_start),
        .CTS           (cts),
        .Tx            (np_tx),
        .Tx_Busy       (np_busy),
        .Tx_Done       (np_done)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mwait(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
        end
    endtask

    // Line monitor: decodes each frame at bit centres and checks it
    // against the oldest queued word.
    initial begin : monitor
        logic [11:0] f;
        logic [7:0]  e;
        bit          ab;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && rst === 1'b0) begin
                ab = 1'b0;
                f  = '0;
                mwait(7, ab);
                f[11] = tx;
                for (int b = 10; b >= 0; b--) begin
                    mwait(16, ab);
                    f[b] = tx;
                end
                if (ab) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                end else if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("frame_start", f[11], 1'b0);
                    chk("frame_data", f[10:3], e);
                    chk("frame_parity", f[2], ^e);
                    chk("frame_stop", f[1:0], 2'b11);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d,
                        input bit hold,
                        input int cts_at,
                        input int chg_at,
                        input int rst_at);
        int n;
        data  = d;
        start = 1'b1;
        cts   = 1'b1;
        sb.push_back(d);
        if (hold) sb.push_back(d);
        @(negedge clk);
        chk("lat_busy0", busy, 1'b0);
        chk("lat_tx1", tx, 1'b1);
        @(negedge clk);
        chk("start_busy", busy, 1'b1);
        chk("start_tx", tx, 1'b0);
        if (!hold) start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            if (n == cts_at) cts = 1'b0;
            if (n == chg_at) data = 8'hFF;
            if (n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_tx", tx, 1'b1);
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                @(negedge clk);
                rst = 1'b0;
                cts = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk("busy_len", n, 192);
        chk("done_pulse", done, 1'b1);
        cts = 1'b1;
        @(negedge clk);
        if (hold) begin
            chk("b2b_tx", tx, 1'b0);
            chk("b2b_busy", busy, 1'b1);
            start = 1'b0;
            n = 0;
            while (busy === 1'b1 && n < 400) begin
                n++;
                @(negedge clk);
            end
            chk("b2b_len", n, 192);
            chk("b2b_done", done, 1'b1);
            @(negedge clk);
        end
        chk("done_once", done, 1'b0);
    endtask

    task automatic send_np(input logic [7:0] d);
        logic [9:0] bits;
        int n;
        data     = d;
        np_start = 1'b1;
        cts      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("np_start_busy", np_busy, 1'b1);
        np_start = 1'b0;
        bits = '1;
        n = 0;
        while (np_busy === 1'b1 && n < 400) begin
            if (n % 16 == 7 && n / 16 < 10) bits[9 - n / 16] = np_tx;
            n++;
            @(negedge clk);
        end
        chk("np_busy_len", n, 160);
        chk("np_frame", bits, {1'b0, d, 1'b1});
        chk("np_done", np_done, 1'b1);
    endtask

    initial begin : stim
        int bad;
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        send(8'hA5, 1'b0, 0, 0, 0);
        repeat (5) @(negedge clk);
        send(8'h01, 1'b0, 0, 0, 0);
        repeat (5) @(negedge clk);
        send_np(8'h01);
        repeat (5) @(negedge clk);

        data  = 8'h11;
        start = 1'b1;
        cts   = 1'b0;
        bad   = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("cts_wait", bad, 0);
        send(8'h5A, 1'b0, 0, 0, 0);
        repeat (5) @(negedge clk);

        send(8'hC3, 1'b0, 70, 0, 0);
        repeat (5) @(negedge clk);
        send(8'h3C, 1'b0, 0, 96, 0);
        repeat (5) @(negedge clk);
        send(8'h69, 1'b1, 0, 0, 0);
        repeat (5) @(negedge clk);

        send(8'h96, 1'b0, 0, 0, 150);
        repeat (250) @(negedge clk);
        send(8'h96, 1'b0, 0, 0, 0);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b0, 0, 0, 0);
            @(negedge clk);
        end

        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
